cache_refill: RTL and testbench
===============================

# cache_refill

Instruction-fetch stage directly downstream of the icache lookup stage. It accepts one lookup result per handshake. On a hit it selects the 32-bit instruction from the 128-bit line. On a miss it fetches the line over an AXI4 read burst, writes it back into the icache through the write port, and forwards the requested word. It forwards the instruction, its PC and the branch-prediction fields to decode.

## Interface
- Parameters: none. Geometry is fixed by shared defines: 8 sets, 8 ways, 16-byte line, 25-bit tag.
- Clock and reset: one clock; reset is asynchronous and active-high. Ports are named `clock` and `reset`.
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `valid_pre_i` / `ready_pre_o`  in/out  1  handshake with the lookup stage
- `valid_post_o` / `ready_post_i`  out/in  1  handshake with decode
- `flush_i`, `csr_flush_i`  in  1  pipeline flush; both have identical effect
- `tar_hit_i`  in  1  lookup hit
- `araddr_i`  in  32  fetch PC
- `buffer_i`  in  128  hit line data
- `pvalid_i`, `ptaken_i`  in  1  prediction fields
- `ptarget_i`  in  32  predicted target
- `wen_o`  out  1  icache write strobe, one cycle
- `windex_o`, `wway_o`  out  3  write set / way
- `wtag_o`  out  25  write tag
- `wdata_o`  out  128  write line
- `arvalid_o` / `arready_i`  out/in  1  AXI AR handshake
- `araddr_o`  out  32  line-aligned burst address
- `arlen_o`  out  8  constant 3
- `arsize_o`  out  3  constant 2
- `arburst_o`  out  2  constant INCR (2'b01)
- `rvalid_i` / `rready_o`  in/out  1  AXI R handshake
- `rdata_i`  in  32  read beat data
- `rresp_i`  in  2  read response
- `rlast_i`  in  1  last beat
- `inst_o`  out  32  instruction to decode
- `pc_o`  out  32  PC to decode
- `pvalid_o`, `ptaken_o`  out  1  prediction fields to decode
- `ptarget_o`  out  32  predicted target to decode

## Operation
- **States:** IDLE, AR, R, REFILL, WAIT_READY.
- **Reset:** state is IDLE, so `ready_pre_o`=1. All other outputs and registers reset to 0, except the constant AXI fields.
- **IDLE**
  - Accept when `valid_pre_i && ready_pre_o` and no flush.
  - On accept, capture PC, prediction fields and error flag=0.
  - Hit: `inst_o` = `buffer_i[32*araddr_i[3:2] +: 32]`, next state WAIT_READY.
  - Miss: next state AR.
- **AR**
  - `arvalid_o`=1, `araddr_o` = {pc[31:4], 4'b0}.
  - Move to R on `arready_i`.
- **R**
  - `rready_o`=1.
  - Beat k (k = 0..3) is written into `line[32k+31:32k]`.
  - The error flag is set if any `rresp_i` is non-zero.
  - Move to REFILL on `rvalid_i && rlast_i`.
- **REFILL**
  - Lasts exactly one cycle.
  - `wen_o` = !error.
  - `windex_o` = pc[6:4], `wtag_o` = pc[31:7], `wdata_o` = line, `wway_o` = victim[pc[6:4]].
  - The victim counter for the set increments modulo 8 only when `wen_o` is 1.
  - `inst_o` = error ? 32'h0 : word pc[3:2] of the line; all-zero is illegal, so decode traps.
  - Next state is WAIT_READY, or IDLE if the discard flag is set.
- **WAIT_READY**
  - `valid_post_o`=1; all outputs are held stable.
  - Move to IDLE on `ready_post_i`.
- **Victim counters:** per-set 3-bit round-robin, reset to 0. There is no preference for invalid ways.
- **Flush**
  - In IDLE or WAIT_READY: go to IDLE immediately; nothing is accepted that cycle.
  - In AR, R or REFILL: set the discard flag. The AXI transaction runs to completion, since AR cannot be withdrawn and all beats are drained. The refill is still written, then the stage returns to IDLE without `valid_post_o`.
  - The discard flag clears on entry to IDLE.
- **Simultaneous flush and `ready_post_i`:** IDLE, no double transfer.

## Timing
- **Hit:** accepted in cycle T; `valid_post_o`=1 in T+1.
- **Miss:** `arvalid_o`=1 in T+1. With zero-wait memory, beats arrive in T+2..T+5. REFILL is in T+6 and `valid_post_o`=1 in T+7.
- **`wen_o`:** high for one cycle. The icache samples it on the falling edge of that cycle, so the line is visible to the next lookup.
- **`ready_pre_o`:** 1 only in IDLE, so there is at most one outstanding fetch.
- **Reset mid-burst:** immediately IDLE; the AXI slave must be reset with the same signal.

## Structure
- **Shared defines:** state encodings, LINE_BEATS=4, ARLEN=3, ARSIZE=2, BURST_INCR=2'b01, and the index/tag bit ranges shared with the lookup stage.
- **Sub-module `refill_victim`:** eight 3-bit round-robin counters. Inputs: index and advance strobe. Output: victim way.

## Test plan
- **Hit:** `araddr_i`=0x8000_0008, `tar_hit_i`=1, `buffer_i`={0x44,0x33,0x22,0x11} (word 3 down to word 0).
  - Expect `inst_o`=0x33 with `valid_post_o` one cycle later and no AR.
- **Miss:** `araddr_i`=0x8000_0014, `tar_hit_i`=0, beats 0x11,0x22,0x33,0x44.
  - Expect `araddr_o`=0x8000_0010 and a one-cycle `wen_o`.
  - Expect `windex_o`=1, `wway_o`=0, `wtag_o`=0x100_0000, `wdata_o`={0x44,0x33,0x22,0x11}, `inst_o`=0x22.
- **Victim rotation:** a second miss to set 1 gives `wway_o`=1; nine misses to set 1 wrap `wway_o` back to 0.
- **Flush mid-burst:** assert `flush_i` during beat 2.
  - Expect all 4 beats drained and `wen_o` still pulsed.
  - Expect no `valid_post_o`, and `ready_pre_o`=1 the cycle after REFILL.
- **Error response:** `rresp_i`=2'b10 on beat 1.
  - Expect `wen_o`=0, counter unchanged, `inst_o`=0x0 delivered.
- **Backpressure:** hold `ready_post_i`=0 for 5 cycles.
  - Expect `valid_post_o`, `inst_o` and `pc_o` stable, and `ready_pre_o`=0 throughout.

Source files
------------

// File: rtl/cache_refill_pkg.sv
// Shared definitions for the instruction-fetch refill stage: FSM states,
// AXI burst constants and the icache index/tag geometry.
package cache_refill_pkg;

    typedef enum logic [2:0] {
        IDLE,
        AR,
        R,
        REFILL,
        WAIT_READY
    } state_t;

    localparam int unsigned SETS       = 8;
    localparam int unsigned WAYS       = 8;
    localparam int unsigned LINE_BEATS = 4;
    localparam int unsigned INDEX_LO   = 4;
    localparam int unsigned INDEX_HI   = 6;
    localparam int unsigned TAG_LO     = 7;
    localparam int unsigned TAG_HI     = 31;

    localparam logic [7:0] ARLEN      = 8'd3;
    localparam logic [2:0] ARSIZE     = 3'd2;
    localparam logic [1:0] BURST_INCR = 2'b01;

    function automatic logic [31:0] line_word(input logic [127:0] line, input logic [1:0] sel);
        return line[{sel, 5'b00000} +: 32];
    endfunction

endpackage

// File: rtl/cache_refill_victim.sv
// Per-set round-robin victim selection; one 3-bit counter per set,
// advanced only when a line is actually written into that set.
module refill_victim
    import cache_refill_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] index,
    input  logic       advance,
    output logic [2:0] way
);

    logic [2:0] ctr [SETS];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < SETS; i++) ctr[i] <= '0;
        end else if (advance) begin
            ctr[index] <= ctr[index] + 3'd1;
        end
    end

    assign way = ctr[index];

endmodule

// File: rtl/cache_refill.sv
// Fetch stage after icache lookup: forwards hits directly, refills misses
// over an AXI4 INCR burst, writes the line back and forwards the word.
module cache_refill
    import cache_refill_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         valid_pre_i,
    output logic         ready_pre_o,
    output logic         valid_post_o,
    input  logic         ready_post_i,
    input  logic         flush_i,
    input  logic         csr_flush_i,
    input  logic         tar_hit_i,
    input  logic [31:0]  araddr_i,
    input  logic [127:0] buffer_i,
    input  logic         pvalid_i,
    input  logic         ptaken_i,
    input  logic [31:0]  ptarget_i,
    output logic         wen_o,
    output logic [2:0]   windex_o,
    output logic [2:0]   wway_o,
    output logic [24:0]  wtag_o,
    output logic [127:0] wdata_o,
    output logic         arvalid_o,
    input  logic         arready_i,
    output logic [31:0]  araddr_o,
    output logic [7:0]   arlen_o,
    output logic [2:0]   arsize_o,
    output logic [1:0]   arburst_o,
    input  logic         rvalid_i,
    output logic         rready_o,
    input  logic [31:0]  rdata_i,
    input  logic [1:0]   rresp_i,
    input  logic         rlast_i,
    output logic [31:0]  inst_o,
    output logic [31:0]  pc_o,
    output logic         pvalid_o,
    output logic         ptaken_o,
    output logic [31:0]  ptarget_o
);

    state_t         state, state_next;
    logic           flush, accept, busy;
    logic [31:0]    pc, ptarget, inst;
    logic           pvalid, ptaken, error, discard;
    logic [127:0]   line;
    logic [1:0]     beat;
    logic [31:0]    refill_word;

    assign flush       = flush_i | csr_flush_i;
    assign accept      = (state == IDLE) && valid_pre_i && !flush;
    assign busy        = (state == AR) || (state == R) || (state == REFILL);
    assign refill_word = error ? '0 : line_word(line, pc[3:2]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (accept) state_next = tar_hit_i ? WAIT_READY : AR;
            AR:         if (arready_i) state_next = R;
            R:          if (rvalid_i && rlast_i) state_next = REFILL;
            REFILL:     state_next = (discard || flush) ? IDLE : WAIT_READY;
            WAIT_READY: if (flush || ready_post_i) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_pre_o  = (state == IDLE);
        arvalid_o    = (state == AR);
        rready_o     = (state == R);
        wen_o        = (state == REFILL) && !error;
        valid_post_o = (state == WAIT_READY);
        inst_o       = (state == REFILL) ? refill_word : inst;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc      <= '0;
            ptarget <= '0;
            pvalid  <= 1'b0;
            ptaken  <= 1'b0;
            inst    <= '0;
            line    <= '0;
            beat    <= '0;
            error   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    pc      <= araddr_i;
                    ptarget <= ptarget_i;
                    pvalid  <= pvalid_i;
                    ptaken  <= ptaken_i;
                    error   <= 1'b0;
                    beat    <= '0;
                    if (tar_hit_i) inst <= line_word(buffer_i, araddr_i[3:2]);
                end
                R: if (rvalid_i) begin
                    line[{beat, 5'b00000} +: 32] <= rdata_i;
                    beat <= beat + 2'd1;
                    if (rresp_i != 2'b00) error <= 1'b1;
                end
                REFILL: inst <= refill_word;
                default: ;
            endcase
        end
    end

    // Clearing on IDLE entry wins over a flush arriving in the REFILL cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                    discard <= 1'b0;
        else if (state_next == IDLE)  discard <= 1'b0;
        else if (flush && busy)       discard <= 1'b1;
    end

    refill_victim u_victim (
        .clock   (clock),
        .reset   (reset),
        .index   (pc[INDEX_HI:INDEX_LO]),
        .advance (wen_o),
        .way     (wway_o)
    );

    assign windex_o  = pc[INDEX_HI:INDEX_LO];
    assign wtag_o    = pc[TAG_HI:TAG_LO];
    assign wdata_o   = line;
    assign araddr_o  = {pc[31:4], 4'b0000};
    assign arlen_o   = ARLEN;
    assign arsize_o  = ARSIZE;
    assign arburst_o = BURST_INCR;
    assign pc_o      = pc;
    assign pvalid_o  = pvalid;
    assign ptaken_o  = ptaken;
    assign ptarget_o = ptarget;

endmodule

// File: tb/tb_cache_refill.sv
// Directed bench for cache_refill: hit, miss, victim rotation, flush,
// error response and decode backpressure.
module tb_cache_refill;

    logic         clock = 1'b0;
    logic         reset;
    logic         valid_pre_i, ready_pre_o, valid_post_o, ready_post_i;
    logic         flush_i, csr_flush_i, tar_hit_i;
    logic [31:0]  araddr_i;
    logic [127:0] buffer_i;
    logic         pvalid_i, ptaken_i;
    logic [31:0]  ptarget_i;
    logic         wen_o;
    logic [2:0]   windex_o, wway_o;
    logic [24:0]  wtag_o;
    logic [127:0] wdata_o;
    logic         arvalid_o, arready_i;
    logic [31:0]  araddr_o;
    logic [7:0]   arlen_o;
    logic [2:0]   arsize_o;
    logic [1:0]   arburst_o;
    logic         rvalid_i, rready_o;
    logic [31:0]  rdata_i;
    logic [1:0]   rresp_i;
    logic         rlast_i;
    logic [31:0]  inst_o, pc_o, ptarget_o;
    logic         pvalid_o, ptaken_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    cache_refill dut (
        .clock(clock), .reset(reset),
        .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o),
        .valid_post_o(valid_post_o), .ready_post_i(ready_post_i),
        .flush_i(flush_i), .csr_flush_i(csr_flush_i),
        .tar_hit_i(tar_hit_i), .araddr_i(araddr_i), .buffer_i(buffer_i),
        .pvalid_i(pvalid_i), .ptaken_i(ptaken_i), .ptarget_i(ptarget_i),
        .wen_o(wen_o), .windex_o(windex_o), .wway_o(wway_o),
        .wtag_o(wtag_o), .wdata_o(wdata_o),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
        .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i),
        .rresp_i(rresp_i), .rlast_i(rlast_i),
        .inst_o(inst_o), .pc_o(pc_o), .pvalid_o(pvalid_o),
        .ptaken_o(ptaken_o), .ptarget_o(ptarget_o)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One miss with zero-wait memory; err_beat/flush_beat of 4 means none.
    task automatic do_miss(input logic [31:0] addr, input logic [127:0] line,
                           input int unsigned err_beat, input int unsigned flush_beat,
                           input logic [2:0] exp_way);
        logic [31:0] word;
        logic [31:0] exp_inst;
        logic        exp_wen;
        word     = line[{addr[3:2], 5'b00000} +: 32];
        exp_wen  = (err_beat > 3);
        exp_inst = exp_wen ? word : 32'h0;
        valid_pre_i = 1'b1; tar_hit_i = 1'b0; araddr_i = addr;
        tick();
        valid_pre_i = 1'b0;
        check("miss_arvalid", {127'b0, arvalid_o}, 128'd1);
        check("miss_araddr", {96'b0, araddr_o}, {96'b0, addr[31:4], 4'b0000});
        check("miss_ready_pre", {127'b0, ready_pre_o}, 128'd0);
        arready_i = 1'b1;
        tick();
        arready_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("beat_rready", {127'b0, rready_o}, 128'd1);
            rvalid_i = 1'b1;
            rdata_i  = line[32*k +: 32];
            rresp_i  = (k == int'(err_beat)) ? 2'b10 : 2'b00;
            rlast_i  = (k == 3);
            flush_i  = (k == int'(flush_beat));
            tick();
        end
        rvalid_i = 1'b0; rlast_i = 1'b0; rresp_i = 2'b00; flush_i = 1'b0;
        check("refill_wen", {127'b0, wen_o}, {127'b0, exp_wen});
        check("refill_windex", {125'b0, windex_o}, {125'b0, addr[6:4]});
        check("refill_wway", {125'b0, wway_o}, {125'b0, exp_way});
        check("refill_wtag", {103'b0, wtag_o}, {103'b0, addr[31:7]});
        check("refill_wdata", wdata_o, line);
        check("refill_inst", {96'b0, inst_o}, {96'b0, exp_inst});
        tick();
        check("post_wen", {127'b0, wen_o}, 128'd0);
        if (flush_beat < 4) begin
            check("flush_valid_post", {127'b0, valid_post_o}, 128'd0);
            check("flush_ready_pre", {127'b0, ready_pre_o}, 128'd1);
        end else begin
            check("miss_valid_post", {127'b0, valid_post_o}, 128'd1);
            check("miss_inst", {96'b0, inst_o}, {96'b0, exp_inst});
            check("miss_pc", {96'b0, pc_o}, {96'b0, addr});
            ready_post_i = 1'b1;
            tick();
            ready_post_i = 1'b0;
            check("miss_done_ready_pre", {127'b0, ready_pre_o}, 128'd1);
        end
    endtask

    initial begin
        logic [127:0] line_a;
        reset = 1'b1;
        valid_pre_i = 0; ready_post_i = 0; flush_i = 0; csr_flush_i = 0;
        tar_hit_i = 0; araddr_i = '0; buffer_i = '0;
        pvalid_i = 0; ptaken_i = 0; ptarget_i = '0;
        arready_i = 0; rvalid_i = 0; rdata_i = '0; rresp_i = '0; rlast_i = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        check("rst_ready_pre", {127'b0, ready_pre_o}, 128'd1);
        check("rst_valid_post", {127'b0, valid_post_o}, 128'd0);
        check("rst_wen", {127'b0, wen_o}, 128'd0);
        check("rst_arvalid", {127'b0, arvalid_o}, 128'd0);
        check("rst_rready", {127'b0, rready_o}, 128'd0);
        check("rst_inst", {96'b0, inst_o}, 128'd0);
        check("rst_pc", {96'b0, pc_o}, 128'd0);
        check("rst_arlen", {120'b0, arlen_o}, 128'd3);
        check("rst_arsize", {125'b0, arsize_o}, 128'd2);
        check("rst_arburst", {126'b0, arburst_o}, 128'd1);

        // Hit, then five cycles of decode backpressure
        line_a = {32'h44, 32'h33, 32'h22, 32'h11};
        valid_pre_i = 1; tar_hit_i = 1; araddr_i = 32'h8000_0008; buffer_i = line_a;
        pvalid_i = 1; ptaken_i = 1; ptarget_i = 32'h8000_0100;
        tick();
        valid_pre_i = 0; tar_hit_i = 0; pvalid_i = 0; ptaken_i = 0; ptarget_i = '0;
        buffer_i = '0;
        check("hit_valid_post", {127'b0, valid_post_o}, 128'd1);
        check("hit_inst", {96'b0, inst_o}, 128'h33);
        check("hit_pc", {96'b0, pc_o}, 128'h8000_0008);
        check("hit_pvalid", {127'b0, pvalid_o}, 128'd1);
        check("hit_ptaken", {127'b0, ptaken_o}, 128'd1);
        check("hit_ptarget", {96'b0, ptarget_o}, 128'h8000_0100);
        check("hit_no_ar", {127'b0, arvalid_o}, 128'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid_post", {127'b0, valid_post_o}, 128'd1);
            check("bp_inst", {96'b0, inst_o}, 128'h33);
            check("bp_pc", {96'b0, pc_o}, 128'h8000_0008);
            check("bp_ready_pre", {127'b0, ready_pre_o}, 128'd0);
            check("bp_no_ar", {127'b0, arvalid_o}, 128'd0);
        end
        ready_post_i = 1;
        tick();
        ready_post_i = 0;
        check("hit_done_ready_pre", {127'b0, ready_pre_o}, 128'd1);
        check("hit_done_valid_post", {127'b0, valid_post_o}, 128'd0);

        // Flush in IDLE blocks acceptance
        valid_pre_i = 1; tar_hit_i = 1; araddr_i = 32'h0; buffer_i = line_a; flush_i = 1;
        tick();
        valid_pre_i = 0; tar_hit_i = 0; flush_i = 0;
        check("idle_flush_ready_pre", {127'b0, ready_pre_o}, 128'd1);
        check("idle_flush_valid_post", {127'b0, valid_post_o}, 128'd0);

        // csr_flush together with ready_post in WAIT_READY: single return to IDLE
        valid_pre_i = 1; tar_hit_i = 1; araddr_i = 32'h0000_0004;
        tick();
        valid_pre_i = 0; tar_hit_i = 0;
        check("hit2_inst", {96'b0, inst_o}, 128'h22);
        csr_flush_i = 1; ready_post_i = 1;
        tick();
        csr_flush_i = 0; ready_post_i = 0;
        check("csr_flush_ready_pre", {127'b0, ready_pre_o}, 128'd1);
        check("csr_flush_valid_post", {127'b0, valid_post_o}, 128'd0);
        tick();
        check("csr_flush_no_repeat", {127'b0, valid_post_o}, 128'd0);

        // Main miss: set 1, tag 0x100_0000, word 1
        do_miss(32'h8000_0014, line_a, 4, 4, 3'd0);

        // Victim rotation on set 1: ways 1..7, then wrap to 0 on the ninth miss
        for (int i = 1; i < 9; i++) begin
            do_miss(32'h8000_0010 + (i << 7),
                    {32'h4000_0000 + i, 32'h3000_0000 + i, 32'h2000_0000 + i, 32'h1000_0000 + i},
                    4, 4, 3'(i));
        end

        // Flush during beat 2 on set 3: drained, still written, not delivered
        do_miss(32'h0000_0038, {32'hD4, 32'hC3, 32'hB2, 32'hA1}, 4, 2, 3'd0);

        // Error on beat 1, set 3: no write, counter stays at 1, zero delivered
        do_miss(32'h0000_0034, {32'hE4, 32'hE3, 32'hE2, 32'hE1}, 1, 4, 3'd1);
        do_miss(32'h0000_0030, {32'hF4, 32'hF3, 32'hF2, 32'hF1}, 4, 4, 3'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
